// File: rtl/neuron_mac_unit.sv
// ---------------------------------------------------------------------------
// neuron_mac_unit
//
// Drains packed operand words from a show-ahead input buffer and computes one
// neuron output: sum over NUM_INPUTS of (input * weight) plus bias, in signed
// fixed point with FRAC_BITS fractional bits. The result is shifted back to
// Q.FRAC_BITS, saturated to signed 32 bits and offered on a valid/ready
// handshake.
//
// Each buffer word carries a signed Q8.8 input in bits [31:16] and a signed
// Q8.8 weight in bits [15:0].
//
// Optional feature: define NEURON_MAC_RELU_EN to clamp negative results to 0.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   start            one-cycle pulse, begins a neuron (honoured only when idle)
//   bias             signed Q(32-FRAC_BITS).FRAC_BITS bias, sampled on start
//   buf_read_data    buffer head word, valid whenever buf_empty is low
//   buf_empty        buffer holds no data
//   buf_read_enable  pop strobe to the buffer
//   result_data      signed Q.FRAC_BITS neuron result
//   result_valid     result_data is valid
//   result_ready     downstream accepts the result
//   busy             high whenever the unit is not idle
// ---------------------------------------------------------------------------
module neuron_mac_unit #(
  parameter int NUM_INPUTS = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int FRAC_BITS  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic [31:0] buf_read_data,
  input  logic        buf_empty,
  output logic        buf_read_enable,
  output logic [31:0] result_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    FINISH,
    OUTPUT
  } state_e;

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [31:0]          prod_q, prod_d;
  logic                        prodValid_q, prodValid_d;
  logic [31:0]                 bias_q, bias_d;
  logic [31:0]                 resultData_q, resultData_d;
  logic                        resultValid_q, resultValid_d;

  logic                        pop;
  logic signed [15:0]          opIn;
  logic signed [15:0]          opWeight;
  logic signed [ACC_WIDTH-1:0] biasExt;
  logic signed [ACC_WIDTH-1:0] sumFull;
  logic signed [ACC_WIDTH-1:0] sumShifted;
  logic [ACC_WIDTH-32:0]       sumUpper;
  logic [31:0]                 satResult;
  logic [31:0]                 finalResult;

  // Pops are only ever issued while accumulating and only against a
  // non-empty buffer, so an empty buffer simply stalls the neuron.
  assign pop             = (state_q == ACCUM) && !buf_empty;
  assign buf_read_enable = pop;
  assign busy            = (state_q != IDLE);
  assign result_data     = resultData_q;
  assign result_valid    = resultValid_q;

  assign opIn     = buf_read_data[31:16];
  assign opWeight = buf_read_data[15:0];

  // Result path used in FINISH. The bias is aligned to the accumulator's
  // 2*FRAC_BITS fraction before adding, then the sum is brought back to
  // FRAC_BITS with an arithmetic shift (truncation toward negative infinity).
  // The shifted value fits in 32 signed bits only when every bit from 31
  // upward agrees; otherwise it is clamped to the extreme of its sign.
  always_comb begin
    biasExt    = {{(ACC_WIDTH-32){bias_q[31]}}, bias_q};
    sumFull    = acc_q + (biasExt <<< FRAC_BITS);
    sumShifted = sumFull >>> FRAC_BITS;
    sumUpper   = sumShifted[ACC_WIDTH-1:31];
    if ((&sumUpper) || !(|sumUpper)) begin
      satResult = sumShifted[31:0];
    end else if (sumShifted[ACC_WIDTH-1]) begin
      satResult = 32'h8000_0000;
    end else begin
      satResult = 32'h7FFF_FFFF;
    end
`ifdef NEURON_MAC_RELU_EN
    finalResult = satResult[31] ? 32'h0000_0000 : satResult;
`else
    finalResult = satResult;
`endif
  end

  // Next-state logic. The product stage is one register deep: a product
  // registered on a pop is folded into the accumulator on the following
  // cycle whatever the state, which is why DRAIN exists to absorb the last
  // one before the result is formed.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    prod_d        = prod_q;
    prodValid_d   = 1'b0;
    bias_d        = bias_q;
    resultData_d  = resultData_q;
    resultValid_d = resultValid_q;

    if (prodValid_q) begin
      acc_d = acc_q + ACC_WIDTH'(prod_q);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          bias_d  = bias;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (pop) begin
          prod_d      = 32'(opIn) * 32'(opWeight);
          prodValid_d = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_INPUTS - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = FINISH;
      end
      FINISH: begin
        resultData_d  = finalResult;
        resultValid_d = 1'b1;
        state_d       = OUTPUT;
      end
      OUTPUT: begin
        if (resultValid_q && result_ready) begin
          resultValid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial neuron.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      prod_q        <= '0;
      prodValid_q   <= 1'b0;
      bias_q        <= '0;
      resultData_q  <= '0;
      resultValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      prod_q        <= prod_d;
      prodValid_q   <= prodValid_d;
      bias_q        <= bias_d;
      resultData_q  <= resultData_d;
      resultValid_q <= resultValid_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac_unit
//
// Directed bench for neuron_mac_unit with NUM_INPUTS=4. A simple array-based
// show-ahead buffer feeds the DUT. A behavioural model predicts busy,
// result_valid, result_data and the pop strobe each cycle, computing the
// neuron value with plain 64-bit arithmetic; the directed tests additionally
// pin hand-computed literal results and latency.
// ---------------------------------------------------------------------------
module tb_neuron_mac_unit;

  localparam int NI    = 4;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] bias;
  logic [31:0] buf_read_data;
  logic        buf_empty;
  logic        buf_read_enable;
  logic [31:0] result_data;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  logic [31:0] mem [DEPTH];
  int          head = 0;
  int          tail = 0;
  logic        bufFlush;

  int          testsRun = 0;
  int          testsFailed = 0;

  logic        mBusy;
  logic        mValid;
  logic [31:0] mData;
  int          mPops;
  int          mWait;
  int          mStartIdx;
  logic [31:0] mBias;
  logic        expRe;

  neuron_mac_unit #(
    .NUM_INPUTS(NI),
    .ACC_WIDTH (48),
    .FRAC_BITS (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .bias           (bias),
    .buf_read_data  (buf_read_data),
    .buf_empty      (buf_empty),
    .buf_read_enable(buf_read_enable),
    .result_data    (result_data),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  assign buf_read_data = mem[head % DEPTH];
  assign buf_empty     = (head == tail);

  // Buffer head advances on each pop seen at the clock edge.
  always @(posedge clk) begin
    if (bufFlush) begin
      head <= tail;
    end else if (buf_read_enable) begin
      head <= head + 1;
    end
  end

  // Neuron value from the words it consumed: exact integer dot product in
  // Q16.16, bias scaled up by 256, floor-divided by 256, clamped to int32.
  function automatic logic [31:0] neuronModel(input int startIdx, input logic [31:0] b);
    longint sum;
    longint q;
    logic [31:0] w;
    logic [31:0] r;
    sum = 0;
    for (int i = 0; i < NI; i++) begin
      w = mem[(startIdx + i) % DEPTH];
      sum += longint'($signed(w[31:16])) * longint'($signed(w[15:0]));
    end
    sum += longint'($signed(b)) * 256;
    q = sum >>> 8;
    if (q > 64'sd2147483647) r = 32'h7FFF_FFFF;
    else if (q < -64'sd2147483648) r = 32'h8000_0000;
    else r = q[31:0];
`ifdef NEURON_MAC_RELU_EN
    if (r[31]) r = 32'h0;
`endif
    return r;
  endfunction

  // Cycle model: a neuron starts when idle, takes one word per edge the
  // buffer is non-empty until NI words are taken, shows its result two
  // edges after the last word, and ends on the handshake.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mBusy  <= 1'b0;
      mValid <= 1'b0;
      mData  <= 32'h0;
      mPops  <= 0;
      mWait  <= 0;
    end else if (!mBusy) begin
      if (start) begin
        mBusy     <= 1'b1;
        mPops     <= 0;
        mWait     <= 0;
        mStartIdx <= head;
        mBias     <= bias;
      end
    end else if (mValid) begin
      if (result_ready) begin
        mValid <= 1'b0;
        mBusy  <= 1'b0;
      end
    end else if (mPops < NI) begin
      if (!buf_empty) begin
        mPops <= mPops + 1;
        if (mPops + 1 == NI) mWait <= 2;
      end
    end else begin
      if (mWait == 1) begin
        mValid <= 1'b1;
        mData  <= neuronModel(mStartIdx, mBias);
      end
      mWait <= mWait - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    expRe = mBusy && !mValid && (mPops < NI) && !buf_empty;
    checkOutput("busy", {31'b0, busy}, {31'b0, mBusy});
    checkOutput("result_valid", {31'b0, result_valid}, {31'b0, mValid});
    checkOutput("buf_read_enable", {31'b0, buf_read_enable}, {31'b0, expRe});
    if (mValid) checkOutput("result_data", result_data, mData);
  end

  task automatic pushWord(input logic [31:0] w);
    mem[tail % DEPTH] = w;
    tail = tail + 1;
  endtask

  task automatic pushWords(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) pushWord(w);
  endtask

  task automatic flushBuffer();
    bufFlush = 1'b1;
    @(negedge clk);
    bufFlush = 1'b0;
  endtask

  // Called at a falling edge: one-cycle start pulse with the given bias.
  task automatic applyStimulus(input logic [31:0] b);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitValid(input string name, input logic [31:0] exp, output int lat);
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!result_valid) checkOutput({name, "_timeout"}, 32'h0, 32'h1);
    else checkOutput(name, result_data, exp);
  endtask

  task automatic handshake(input string name);
    result_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, "_idle"}, {31'b0, busy}, 32'h0);
  endtask

  logic [31:0] negSatExp;
  int          lat;
  int          expHead;
  int          startHead;
  int          guard;

  initial begin
    reset_n = 1'b0; start = 1'b0; bias = 32'h0; result_ready = 1'b1; bufFlush = 1'b0;
`ifdef NEURON_MAC_RELU_EN
    negSatExp = 32'h0000_0000;
`else
    negSatExp = 32'h8000_0000;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_valid", {31'b0, result_valid}, 32'h0);
    checkOutput("rst_data", result_data, 32'h0);
    checkOutput("rst_rden", {31'b0, buf_read_enable}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    expHead = 0;

    // Basic dot product: 4 x (1.0*2.0) + 1.0 = 9.0, valid 3 cycles after last pop
    pushWords(32'h0100_0200, 4);
    applyStimulus(32'h0000_0100);
    waitValid("basic", 32'h0000_0900, lat);
    checkOutput("basic_latency", lat, 32'd6);
    handshake("basic");
    expHead += NI;
    checkOutput("basic_pops", head, expHead);

    // Stall on empty: one word every 3 cycles; -6.5 + 2.0 = -4.5
    applyStimulus(32'h0000_0200);
    pushWord(32'h0180_FF00);
    repeat (3) @(negedge clk); pushWord(32'h0040_0200);
    repeat (3) @(negedge clk); pushWord(32'hFE00_0300);
    repeat (3) @(negedge clk); pushWord(32'h0100_0080);
    waitValid("stall", 32'hFFFF_FB80, lat);
    handshake("stall");
    expHead += NI;
    checkOutput("stall_pops", head, expHead);

    // Backpressure with extra words waiting and a start pulse during OUTPUT
    result_ready = 1'b0;
    pushWords(32'h0080_0100, 6);
    applyStimulus(32'h0);
    waitValid("bp", 32'h0000_0200, lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("bp_hold_valid", {31'b0, result_valid}, 32'h1);
      checkOutput("bp_hold_data", result_data, 32'h0000_0200);
    end
    handshake("bp");
    checkOutput("bp_valid_low", {31'b0, result_valid}, 32'h0);
    expHead += NI;
    checkOutput("bp_pops", head, expHead);
    flushBuffer();
    expHead = tail;

    // Positive saturation
    pushWords(32'h7FFF_7FFF, 4);
    applyStimulus(32'h7FFF_FFFF);
    waitValid("sat_pos", 32'h7FFF_FFFF, lat);
    handshake("sat_pos");
    // Negative saturation (clamped to 0 when ReLU is built in)
    pushWords(32'h8000_7FFF, 4);
    applyStimulus(32'h8000_0000);
    waitValid("sat_neg", negSatExp, lat);
    handshake("sat_neg");
    expHead += 2 * NI;
    checkOutput("sat_pops", head, expHead);

    // Reset after 2 of 4 pops, then a fresh neuron: 4 x 2.0 = 8.0
    pushWords(32'h0100_0100, 4);
    startHead = head;
    applyStimulus(32'h0000_7F00);
    guard = 0;
    while ((head - startHead) < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rstmid_twopops", head - startHead, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rstmid_busy", {31'b0, busy}, 32'h0);
    checkOutput("rstmid_valid", {31'b0, result_valid}, 32'h0);
    checkOutput("rstmid_data", result_data, 32'h0);
    checkOutput("rstmid_rden", {31'b0, buf_read_enable}, 32'h0);
    @(negedge clk);
    flushBuffer();
    reset_n = 1'b1;
    @(negedge clk);
    expHead = tail;
    pushWords(32'h0200_0100, 4);
    applyStimulus(32'h0);
    waitValid("rstmid_new", 32'h0000_0800, lat);
    handshake("rstmid_new");
    expHead += NI;
    checkOutput("rstmid_pops", head, expHead);

    // Back-to-back neurons draining 8 words
    pushWords(32'h0100_0100, 8);
    applyStimulus(32'h0);
    waitValid("b2b_first", 32'h0000_0400, lat);
    handshake("b2b_first");
    applyStimulus(32'h0);
    waitValid("b2b_second", 32'h0000_0400, lat);
    handshake("b2b_second");
    checkOutput("b2b_empty", {31'b0, buf_empty}, 32'h1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/neuron_mac_unit.md
Name: neuron_mac_unit

Overview:
- Downstream consumer of the input data buffer; drains packed operand words and computes one neuron output: dot product plus bias.
- Each 32-bit buffer word carries one signed Q8.8 input (bits [31:16]) and one signed Q8.8 weight (bits [15:0]).
- Result goes out on a valid/ready handshake to the activation/writeback stage.

Parameters:
- NUM_INPUTS, 32, operand words consumed per neuron; legal range 1..1024.
- ACC_WIDTH, 48, signed accumulator width; must be at least 32+$clog2(NUM_INPUTS).
- FRAC_BITS, 8, fractional bits of input, weight, bias and result.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a neuron; honoured only in IDLE
- bias  input  32  signed Q(32-FRAC_BITS).FRAC_BITS bias; sampled on accepted start
- buf_read_data  input  32  show-ahead buffer head word, valid whenever buf_empty=0
- buf_empty  input  1  buffer has no data
- buf_read_enable  output  1  pop strobe to the buffer
- result_data  output  32  signed Q.FRAC_BITS neuron result
- result_valid  output  1  result_data valid
- result_ready  input  1  downstream accepts result
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous on reset_n low: state=IDLE, accumulator=0, counter=0, product pipeline empty, buf_read_enable=0, result_valid=0, result_data=0, busy=0. Deassertion takes effect at the next clock edge.
- States: IDLE, ACCUM, DRAIN, FINISH, OUTPUT.
- IDLE:
  - On start=1: latch bias, clear accumulator and counter, go to ACCUM.
  - start in any other state is ignored.
- ACCUM:
  - buf_read_enable = !buf_empty, combinational, asserted only in ACCUM.
  - On each pop: register product = signed(data[31:16]) * signed(data[15:0]), 32-bit, and set prod_valid; increment counter.
  - On the next cycle, a valid product is sign-extended and added to the accumulator.
  - An empty buffer stalls with no pop and no counter change; there is no timeout.
  - When the pop making counter==NUM_INPUTS occurs, go to DRAIN.
- DRAIN:
  - One cycle; the last product is accumulated.
  - Go to FINISH.
- FINISH:
  - sum = accumulator + (sign-extended bias << FRAC_BITS).
  - Arithmetic shift right by FRAC_BITS.
  - Saturate to signed 32-bit: 0x7FFFFFFF / 0x80000000.
  - Register into result_data, set result_valid, go to OUTPUT.
- OUTPUT:
  - result_data and result_valid are held stable until result_valid && result_ready.
  - On that handshake: result_valid=0 next cycle, go to IDLE.
  - A start arriving in the same cycle as the handshake is ignored.
- Latency with a non-empty buffer: NUM_INPUTS pops in consecutive cycles; result_valid rises 3 cycles after the last pop.
- Arithmetic: all signed two's complement; no rounding (truncation toward negative infinity).
- The block never pops more than NUM_INPUTS words per neuron. Extra buffer data stays for the next neuron.
- Reset mid-operation: partial accumulation is discarded. Words already popped are lost; the upstream must be reset together with this block.

Optional Feature:
- Macro NEURON_MAC_RELU_EN.
- Defined: in FINISH, a negative saturated result is replaced by 0 (ReLU) before registering; positive results are unchanged.
- Undefined: the raw saturated signed result is output.

Test Plan:
- Basic dot product:
  - Stimulus: NUM_INPUTS=4; buffer preloaded with four words of 0x01000200 (1.0*2.0 each); bias=0x00000100 (1.0); start pulse.
  - Response: 4 consecutive pops; result_valid 3 cycles after the last pop; result_data=0x00000900 (9.0).
- Stall on empty:
  - Stimulus: buffer starts empty; one word is written every 3 cycles.
  - Response: buf_read_enable is high only when buf_empty=0; exactly NUM_INPUTS pops; result matches the golden model.
- Backpressure:
  - Stimulus: result_ready=0 for 10 cycles after result_valid rises.
  - Response: result_data and result_valid are stable throughout; no extra pops; start pulses during OUTPUT are ignored; return to IDLE one cycle after ready rises.
- Saturation:
  - Stimulus: 32 words of 0x7FFF7FFF; bias=0x7FFFFFFF.
  - Response: result_data=0x7FFFFFFF.
  - Stimulus: 32 words of 0x80007FFF.
  - Response: result_data=0x80000000 without RELU_EN, 0x00000000 with RELU_EN.
- Reset mid-ACCUM:
  - Stimulus: reset_n low after 2 of 4 pops; then a fresh buffer and start.
  - Response: all outputs 0 immediately on reset; the new result is independent of the aborted partial sum.
- Back-to-back neurons:
  - Stimulus: 8 words of 0x01000100 in the buffer, NUM_INPUTS=4, bias=0; start pulse in IDLE after each handshake.
  - Response: two results of 0x00000400; buffer empty after the second neuron.
